// File: rtl/sim_keymap_pkg.sv
// Shared constants for the simulator keyboard generator: key table, indices,
// FSM encoding and timing defaults.
package sim_keymap_pkg;

   localparam int unsigned GAP_DEFAULT = 4800;
   localparam int unsigned NUM_KEYS    = 11;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned CNT_W       = 16;
   localparam int unsigned KEY_W       = 11;
   localparam int unsigned CODE_W      = 8;

   localparam logic [IDX_W-1:0] KEY_RIGHT  = 4'd0;
   localparam logic [IDX_W-1:0] KEY_LEFT   = 4'd1;
   localparam logic [IDX_W-1:0] KEY_DOWN   = 4'd2;
   localparam logic [IDX_W-1:0] KEY_UP     = 4'd3;
   localparam logic [IDX_W-1:0] KEY_ENTER  = 4'd4;
   localparam logic [IDX_W-1:0] KEY_SPACE  = 4'd5;
   localparam logic [IDX_W-1:0] KEY_1      = 4'd6;
   localparam logic [IDX_W-1:0] KEY_2      = 4'd7;
   localparam logic [IDX_W-1:0] KEY_LSHIFT = 4'd8;
   localparam logic [IDX_W-1:0] KEY_RSHIFT = 4'd9;
   localparam logic [IDX_W-1:0] KEY_ESC    = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_HOLD = 2'd2
   } key_state_e;

   typedef struct packed {
      logic              ext;
      logic [CODE_W-1:0] code;
   } key_entry_t;

   // Button index to PS/2 set-2 make code (E0 prefix flagged by ext).
   function automatic key_entry_t key_lookup(input logic [IDX_W-1:0] idx);
      key_entry_t e;
      case (idx)
         KEY_RIGHT:  e = '{ext: 1'b1, code: 8'h74};
         KEY_LEFT:   e = '{ext: 1'b1, code: 8'h6B};
         KEY_DOWN:   e = '{ext: 1'b1, code: 8'h72};
         KEY_UP:     e = '{ext: 1'b1, code: 8'h75};
         KEY_ENTER:  e = '{ext: 1'b0, code: 8'h5A};
         KEY_SPACE:  e = '{ext: 1'b0, code: 8'h29};
         KEY_1:      e = '{ext: 1'b0, code: 8'h16};
         KEY_2:      e = '{ext: 1'b0, code: 8'h1E};
         KEY_LSHIFT: e = '{ext: 1'b0, code: 8'h12};
         KEY_RSHIFT: e = '{ext: 1'b0, code: 8'h59};
         KEY_ESC:    e = '{ext: 1'b0, code: 8'h76};
         default:    e = '{ext: 1'b0, code: 8'h00};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/sim_key_select.sv
// Lowest-index priority pick over pending buttons plus scancode lookup.
// Purely combinational.
module sim_key_select
   import sim_keymap_pkg::*;
(
   input  logic [NUM_KEYS-1:0] pending_i,
   output logic                valid_o,
   output logic [IDX_W-1:0]    index_o,
   output logic                ext_o,
   output logic [CODE_W-1:0]   code_o
);

   key_entry_t entry;

   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (pending_i[i] && !valid_o) begin
            valid_o = 1'b1;
            index_o = IDX_W'(i);
         end
      end
      entry  = key_lookup(index_o);
      ext_o  = entry.ext;
      code_o = entry.code;
   end

endmodule

// File: rtl/sim_ps2_keygen.sv
// Turns simulator button level changes into MiSTer ps2_key strobe words,
// one event per GAP clocks, lowest button index first.
module sim_ps2_keygen
   import sim_keymap_pkg::*;
#(
   parameter int unsigned GAP = GAP_DEFAULT
) (
   input  logic             clk_48,
   input  logic             reset,
   input  logic [11:0]      inputs,
   input  logic             enable,
   output logic [KEY_W-1:0] ps2_key,
   output logic             busy
);

   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 2);

   logic [NUM_KEYS-1:0] sync1_q, sync_q, rep_q, pending;
   logic [IDX_W-1:0]    idx_q;
   key_entry_t          entry_q;
   key_state_e          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [KEY_W-1:0]    ps2_key_q;
   logic                busy_q;

   logic                sel_valid, sel_ext, start, emit_level;
   logic [IDX_W-1:0]    sel_index;
   logic [CODE_W-1:0]   sel_code;
   logic                unused_pause;

   assign unused_pause = inputs[11];
   assign pending      = sync_q ^ rep_q;
   assign start        = enable && sel_valid;
   assign emit_level   = sync_q[idx_q];

   sim_key_select u_select (
      .pending_i (pending),
      .valid_o   (sel_valid),
      .index_o   (sel_index),
      .ext_o     (sel_ext),
      .code_o    (sel_code)
   );

   // The last HOLD cycle doubles as the select cycle so back-to-back
   // events land exactly GAP clocks apart.
   always_ff @(posedge clk_48 or posedge reset) begin
      if (reset) begin
         sync1_q   <= '0;
         sync_q    <= '0;
         rep_q     <= '0;
         idx_q     <= '0;
         entry_q   <= '0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ps2_key_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         sync1_q <= inputs[NUM_KEYS-1:0];
         sync_q  <= sync1_q;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  idx_q   <= sel_index;
                  entry_q <= '{ext: sel_ext, code: sel_code};
                  state_q <= ST_EMIT;
                  busy_q  <= 1'b1;
               end
            end
            ST_EMIT: begin
               ps2_key_q    <= {~ps2_key_q[KEY_W-1], emit_level, entry_q};
               rep_q[idx_q] <= emit_level;
               cnt_q        <= GAP_LOAD;
               state_q      <= ST_HOLD;
            end
            ST_HOLD: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (start) begin
                  idx_q   <= sel_index;
                  entry_q <= '{ext: sel_ext, code: sel_code};
                  state_q <= ST_EMIT;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ps2_key = ps2_key_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_sim_ps2_keygen.sv
// Directed and randomized checks of sim_ps2_keygen against an event-level
// model of button changes (GAP = 8).
module tb_sim_ps2_keygen;

   localparam int unsigned GAP  = 8;
   localparam int          HIST = 8192;
   localparam logic [8:0]  TBL [11] = '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h05A,
                                        9'h029, 9'h016, 9'h01E, 9'h012, 9'h059, 9'h076};

   logic        clk_48;
   logic        reset;
   logic [11:0] inputs;
   logic        enable;
   logic [10:0] ps2_key;
   logic        busy;

   int          tests, fails, cyc, busy_cnt;
   logic        last_strobe, exp_strobe;
   int          ev_cyc[$];
   logic [10:0] ev_word[$];
   logic [11:0] in_hist [HIST];

   sim_ps2_keygen #(.GAP(GAP)) dut (
      .clk_48  (clk_48),
      .reset   (reset),
      .inputs  (inputs),
      .enable  (enable),
      .ps2_key (ps2_key),
      .busy    (busy)
   );

   initial clk_48 = 1'b0;
   always #5 clk_48 = ~clk_48;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n clocks; log every strobe toggle as an event with its cycle.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         if (cyc < HIST) in_hist[cyc] = inputs;
         @(posedge clk_48);
         #1;
         cyc++;
         if (reset) begin
            last_strobe = 1'b0;
         end else begin
            if (ps2_key[10] !== last_strobe) begin
               ev_cyc.push_back(cyc);
               ev_word.push_back(ps2_key);
               last_strobe = ps2_key[10];
            end
            if (busy === 1'b1) busy_cnt++;
         end
      end
   endtask

   task automatic expect_ev(input string tag, input int exp_cyc, input logic pressed, input int idx);
      int          c;
      logic [10:0] w;
      check({tag, "_present"}, 32'(ev_cyc.size() != 0), 32'(1));
      exp_strobe = ~exp_strobe;
      if (ev_cyc.size() != 0) begin
         c = ev_cyc.pop_front();
         w = ev_word.pop_front();
         check({tag, "_cycle"}, 32'(c), 32'(exp_cyc));
         check({tag, "_word"}, 32'(w), 32'({exp_strobe, pressed, TBL[idx]}));
      end
   endtask

   task automatic expect_none(input string tag);
      check({tag, "_no_event"}, 32'(ev_cyc.size()), 32'(0));
      ev_cyc.delete();
      ev_word.delete();
   endtask

   initial begin : main
      int          c0, c1, prev_c, c, idx;
      logic        found;
      logic [10:0] w, w0, rep_model;
      logic [11:0] nx;

      tests = 0; fails = 0; cyc = 0; busy_cnt = 0;
      last_strobe = 1'b0; exp_strobe = 1'b0;
      reset = 1'b1; inputs = '0; enable = 1'b1;

      // Reset state
      tick(3);
      check("rst_key", 32'(ps2_key), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      reset = 1'b0;
      tick(4);
      expect_none("idle_after_rst");

      // Single press / release of Enter: word, latency, busy width
      c0 = cyc; busy_cnt = 0;
      inputs[4] = 1'b1;
      tick(GAP + 6);
      expect_ev("enter_press", c0 + 4, 1'b1, 4);
      check("enter_busy_width", 32'(busy_cnt), 32'(GAP));
      check("enter_busy_end", 32'(busy), 32'(0));
      expect_none("enter_press_only");
      c0 = cyc;
      inputs[4] = 1'b0;
      tick(GAP + 6);
      expect_ev("enter_release", c0 + 4, 1'b0, 4);
      expect_none("enter_release_only");

      // Simultaneous changes: ascending order, GAP apart
      c0 = cyc;
      inputs[0] = 1'b1; inputs[3] = 1'b1; inputs[6] = 1'b1;
      tick(3 * GAP + 6);
      expect_ev("multi_b0", c0 + 4, 1'b1, 0);
      expect_ev("multi_b3", c0 + 4 + GAP, 1'b1, 3);
      expect_ev("multi_b6", c0 + 4 + 2 * GAP, 1'b1, 6);
      expect_none("multi_press_only");
      c0 = cyc;
      inputs = '0;
      tick(3 * GAP + 6);
      expect_ev("multi_rel_b0", c0 + 4, 1'b0, 0);
      expect_ev("multi_rel_b3", c0 + 4 + GAP, 1'b0, 3);
      expect_ev("multi_rel_b6", c0 + 4 + 2 * GAP, 1'b0, 6);

      // One-cycle glitch on Space during HOLD is never reported
      c0 = cyc;
      inputs[0] = 1'b1;
      tick(6);
      inputs[5] = 1'b1;
      tick(1);
      inputs[5] = 1'b0;
      tick(2 * GAP + 4);
      expect_ev("glitch_b0", c0 + 4, 1'b1, 0);
      expect_none("glitch_no_space");
      c0 = cyc;
      inputs[0] = 1'b0;
      tick(GAP + 6);
      expect_ev("glitch_b0_rel", c0 + 4, 1'b0, 0);

      // enable low blocks new events; raising it starts one two cycles later
      enable = 1'b0; busy_cnt = 0;
      inputs[7] = 1'b1;
      tick(10);
      expect_none("disabled");
      check("disabled_busy", 32'(busy_cnt), 32'(0));
      c1 = cyc;
      enable = 1'b1;
      tick(GAP + 4);
      expect_ev("enable_b7", c1 + 2, 1'b1, 7);

      // Dropping enable mid-HOLD completes the event, then waits
      c0 = cyc;
      inputs[7] = 1'b0;
      tick(5);
      enable = 1'b0;
      inputs[8] = 1'b1;
      tick(2 * GAP);
      expect_ev("hold_dis_b7", c0 + 4, 1'b0, 7);
      expect_none("hold_dis_wait");
      check("hold_dis_busy", 32'(busy), 32'(0));
      c1 = cyc;
      enable = 1'b1;
      tick(GAP + 2);
      expect_ev("hold_dis_b8", c1 + 2, 1'b1, 8);
      c0 = cyc;
      inputs[8] = 1'b0;
      tick(GAP + 6);
      expect_ev("hold_dis_b8_rel", c0 + 4, 1'b0, 8);

      // Reset in mid-HOLD with Down held, then re-press after release
      c0 = cyc;
      inputs[2] = 1'b1;
      tick(8);
      expect_ev("pre_rst_b2", c0 + 4, 1'b1, 2);
      reset = 1'b1;
      #1;
      check("async_rst_key", 32'(ps2_key), 32'(0));
      check("async_rst_busy", 32'(busy), 32'(0));
      tick(2);
      check("held_rst_key", 32'(ps2_key), 32'(0));
      check("held_rst_busy", 32'(busy), 32'(0));
      expect_none("during_rst");
      exp_strobe = 1'b0;
      c0 = cyc;
      reset = 1'b0;
      tick(GAP + 6);
      expect_ev("post_rst_b2", c0 + 4, 1'b1, 2);
      c0 = cyc;
      inputs[2] = 1'b0;
      tick(GAP + 6);
      expect_ev("post_rst_b2_rel", c0 + 4, 1'b0, 2);

      // Pause bit is ignored
      w0 = ps2_key; busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         inputs[11] = ~inputs[11];
         tick(1);
      end
      inputs[11] = 1'b0;
      tick(4);
      expect_none("pause");
      check("pause_busy", 32'(busy_cnt), 32'(0));
      check("pause_key", 32'(ps2_key), 32'(w0));

      // Random button activity; events replayed onto a level model
      rep_model = '0;
      prev_c = cyc - int'(GAP);
      for (int it = 0; it < 400; it++) begin
         nx = inputs;
         if ($urandom_range(3) == 0) nx[$urandom_range(10)] = ~nx[$urandom_range(10)];
         if ($urandom_range(5) == 0) nx[$urandom_range(10)] = 1'($urandom_range(1));
         nx[11] = 1'($urandom_range(1));
         inputs = nx;
         enable = ($urandom_range(9) != 0);
         tick(1);
      end
      enable = 1'b1;
      tick(11 * GAP + 20);
      while (ev_cyc.size() != 0) begin
         c = ev_cyc.pop_front();
         w = ev_word.pop_front();
         found = 1'b0; idx = 0;
         for (int k = 0; k < 11; k++) begin
            if (w[8:0] === TBL[k]) begin
               found = 1'b1;
               idx = k;
            end
         end
         check("rnd_code", 32'(found), 32'(1));
         exp_strobe = ~exp_strobe;
         check("rnd_strobe", 32'(w[10]), 32'(exp_strobe));
         check("rnd_level", 32'(w[9]), 32'(in_hist[c - 3][idx]));
         check("rnd_spacing", 32'(c - prev_c >= int'(GAP)), 32'(1));
         rep_model[idx] = w[9];
         prev_c = c;
      end
      check("rnd_final_state", 32'(rep_model), 32'(inputs[10:0]));
      check("rnd_final_busy", 32'(busy), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sim_ps2_keygen.md
SIM_PS2_KEYGEN -- requirements
Module: sim_ps2_keygen

Interface
REQ-001 SHALL have parameter GAP, default 4800, meaning the number of clk_48 cycles from one ps2_key event to the next (legal range 2..65535).
REQ-002 SHALL have port clk_48, input, 1 bit: the single system clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port inputs, input, 12 bits: raw simulator button levels (1 = pressed); bits 10..0 are monitored and bit 11 (pause) is ignored.
REQ-005 SHALL have port enable, input, 1 bit: while 0, no new event starts.
REQ-006 SHALL have port ps2_key, output, 11 bits: MiSTer key word, feeds the ZX81 core's ps2_key input.
  - bit 10: strobe, toggles once per event.
  - bit 9: pressed.
  - bit 8: extended (E0).
  - bits 7..0: scancode.
REQ-007 SHALL have port busy, output, 1 bit: 1 while an event is being emitted or spaced.

Function
REQ-008 SHALL pass inputs[10:0] through a 2-flop synchronizer; only synchronized levels (sync) are used.
REQ-009 SHALL hold an 11-bit reported-state register (rep) giving the last level announced for each bit.
REQ-010 SHALL treat bit n as pending when sync[n] differs from rep[n].
REQ-011 SHALL map bit index to {ext, code} as follows:
  - bit 0 = {1, 74h}, bit 1 = {1, 6Bh}, bit 2 = {1, 72h}, bit 3 = {1, 75h}.
  - bit 4 = {0, 5Ah}, bit 5 = {0, 29h}, bit 6 = {0, 16h}, bit 7 = {0, 1Eh}.
  - bit 8 = {0, 12h}, bit 9 = {0, 59h}, bit 10 = {0, 76h}.
REQ-012 SHALL implement an FSM with three states: IDLE, EMIT, HOLD.
REQ-013 In IDLE, with enable=1 and at least one bit pending, SHALL select the lowest pending index n, latch it, and go to EMIT on the next cycle.
REQ-014 In EMIT (exactly 1 cycle), SHALL perform, all on the same edge:
  - ps2_key[10] inverted.
  - ps2_key[9] = sync[n] as sampled in the EMIT cycle.
  - ps2_key[8:0] = table(n).
  - rep[n] = that same level.
  - gap counter loaded with GAP-2.
  - go to HOLD.
REQ-015 In HOLD, SHALL decrement the counter each cycle and go to IDLE when the counter reaches 0.
REQ-016 Consecutive strobe toggles SHALL be exactly GAP cycles apart when changes are back-to-back.
REQ-017 Latency from sync change to strobe toggle SHALL be 2 cycles from IDLE (select cycle plus EMIT), plus the 2-cycle synchronizer delay.
REQ-018 Simultaneous changes SHALL be emitted sequentially in ascending index order, one per GAP cycles.
REQ-019 If a bit returns to its rep level before it is selected, no event SHALL be emitted for it.
REQ-020 If a bit toggles again after its event, a new event SHALL follow; no change may be lost while the level differs from rep.
REQ-021 If the selected bit reverts between select and EMIT, SHALL still emit, using the level sampled in EMIT; this event may repeat the previous state and is acceptable.
REQ-022 enable=0 during EMIT/HOLD SHALL NOT abort; the FSM completes and then waits in IDLE.
REQ-023 ps2_key[9:0] SHALL hold its value between events.
REQ-024 busy SHALL be 1 in EMIT and HOLD, and 0 in IDLE.

Reset
REQ-025 On reset=1, SHALL immediately clear, including mid-HOLD:
  - ps2_key = 0.
  - rep = 0, synchronizer = 0.
  - state = IDLE, counter = 0.
  - busy = 0.
REQ-026 After reset release, buttons already held SHALL generate press events starting at the first IDLE cycle after synchronization.

Structure
REQ-027 The scancode/ext table, bit-index constants, state encoding and the GAP default SHALL live in the shared package sim_keymap_pkg.
REQ-028 The priority encoder plus table lookup SHALL be one sub-module, sim_key_select (pending[10:0] -> valid, index, ext, code), which is purely combinational.
REQ-029 Target size SHALL be 120-400 lines of RTL including the sub-module.

Verification
REQ-030 Press inputs[4] with GAP=8:
  - ps2_key becomes 11'b1_1_0_0101_1010 (strobe=1, pressed, 5Ah).
  - busy is high for exactly 8 cycles.
  - Release yields strobe=0, pressed=0, 5Ah.
REQ-031 Set inputs bits 0, 3 and 6 in the same cycle, GAP=8:
  - Three events in order E0 74, E0 75, 16h.
  - Strobe edges are exactly 8 cycles apart.
REQ-032 Pulse inputs[5] high for 1 cycle while bit 0's HOLD is active: no 29h event is emitted.
REQ-033 Hold enable=0 and press inputs[7]:
  - No event and busy=0.
  - Raising enable yields a 1Eh press 2 cycles later.
REQ-034 Assert reset in mid-HOLD with bit 2 held, then release:
  - All outputs are 0 during reset.
  - After release, E0 72 press is emitted with strobe=1.
REQ-035 Toggle inputs[11] repeatedly: ps2_key and busy never change.
